rotl_64b: RTL

ROTL_64B -- requirements
Module: rotl_64b

---
 rtl/rotate_pkg.sv | 20 ++
 rtl/rotl_stage.sv | 92 +++++++++
 rtl/rotl_64b.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// ----------------------------------------------------------------------------
// rotate_pkg
// Shared constants and types for the 64-bit barrel rotators (rotl_64b and
// rotr_64b).
//   DATA_W    : rotated word width
//   SHIFT_W   : rotate-amount width (0..DATA_W-1)
//   STAGE_NUM : number of 2-bit rotate stages that together cover SHIFT_W
//   SEL_W     : rotate-amount bits consumed by each stage
// ----------------------------------------------------------------------------
package rotate_pkg;

    localparam int DATA_W    = 64;
    localparam int SHIFT_W   = 6;
    localparam int STAGE_NUM = 3;
    localparam int SEL_W     = 2;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SHIFT_W-1:0] shift_t;

endpackage : rotate_pkg

// File: rtl/rotl_stage.sv
// ----------------------------------------------------------------------------
// rotl_stage
// One pipeline stage of the left rotator. Stage STAGE rotates its input word
// left by shift_i[2*STAGE+1:2*STAGE] * 4^STAGE using a fixed 4-way mux, then
// registers the word, the rotate bits still to be applied and a valid bit.
// The stage loads whenever it is empty or the downstream stage advances.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_n_i    : synchronous active-low reset (clears valid and data)
//   valid_i    : upstream word valid
//   data_i     : upstream word
//   shift_i    : upstream remaining rotate amount
//   next_adv_i : downstream stage advances (or accepts) this cycle
//   adv_o      : this stage advances this cycle (upstream may hand over)
//   valid_o    : registered valid
//   data_o     : registered partially rotated word
//   shift_o    : registered remaining rotate amount (own bits cleared)
// ----------------------------------------------------------------------------
module rotl_stage
    import rotate_pkg::*;
#(
    parameter int STAGE = 0
)
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   valid_i,
    input  data_t  data_i,
    input  shift_t shift_i,
    input  logic   next_adv_i,
    output logic   adv_o,
    output logic   valid_o,
    output data_t  data_o,
    output shift_t shift_o
);

    localparam int     LSB       = SEL_W * STAGE;
    localparam int     UNIT      = 1 << LSB;
    // Rotate bits that remain for later stages once this stage's pair is used.
    localparam shift_t KEEP_MASK = ~(shift_t'((1 << SEL_W) - 1) << LSB);

    logic              valid_reg;
    data_t             data_reg;
    shift_t            shift_reg;
    data_t             data_next;
    shift_t            shift_next;
    logic [SEL_W-1:0]  sel;
    data_t             cand [1 << SEL_W];

    // Constant-amount rotations are pure rewiring; the only real logic is the
    // 4-way select between them.
    genvar gi;
    generate
        for (gi = 0; gi < (1 << SEL_W); gi++) begin : g_cand
            localparam int ROT = gi * UNIT;
            if (ROT == 0) begin : g_pass
                assign cand[gi] = data_i;
            end else begin : g_rot
                assign cand[gi] = {data_i[DATA_W-1-ROT:0], data_i[DATA_W-1:DATA_W-ROT]};
            end
        end
    endgenerate

    assign sel        = shift_i[LSB+SEL_W-1:LSB];
    assign data_next  = cand[sel];
    assign shift_next = shift_i & KEEP_MASK;

    // An empty stage can always take a word, otherwise it may only move on
    // when its current word is taken downstream.
    assign adv_o = !valid_reg || next_adv_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            shift_reg <= '0;
        end else if (adv_o) begin
            valid_reg <= valid_i;
            // Payload of an empty slot is don't-care; skip the toggle.
            if (valid_i) begin
                data_reg  <= data_next;
                shift_reg <= shift_next;
            end
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;
    assign shift_o = shift_reg;

endmodule : rotl_stage

// File: rtl/rotl_64b.sv
// ----------------------------------------------------------------------------
// rotl_64b
// Pipelined 64-bit left rotator with valid/ready handshaking on both sides.
// Three rotate stages (by 1/2/3, 4/8/12 and 16/32/48 bit positions) cover
// the full 0..63 range. With REG_OUT=1 a fourth register stage drives the
// outputs (latency 4, capacity 4); with REG_OUT=0 the outputs come straight
// from the third stage (latency 3, capacity 3). Full throughput of one beat
// per cycle when out_ready_i is held high.
//
// Ports
//   clk_i       : clock, rising edge
//   rst_n_i     : synchronous active-low reset; flushes all in-flight beats
//   shift_i     : left-rotate amount, sampled with in_data_i
//   in_data_i   : word to rotate
//   in_valid_i  : input beat valid
//   in_ready_o  : block accepts a beat this cycle
//   out_data_o  : rotated word
//   out_valid_o : out_data_o valid
//   out_ready_i : downstream accepts out_data_o
// ----------------------------------------------------------------------------
module rotl_64b
    import rotate_pkg::*;
#(
    parameter int REG_OUT = 1
)
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    // adv_N: stage N advances this cycle; adv_3 is what the last rotate
    // stage sees downstream (output register or the output port itself).
    logic   adv_0;
    logic   adv_1;
    logic   adv_2;
    logic   adv_3;

    logic   s0_valid;
    logic   s1_valid;
    logic   s2_valid;
    data_t  s0_data;
    data_t  s1_data;
    data_t  s2_data;
    shift_t s0_shift;
    shift_t s1_shift;
    // Every rotate bit has been applied by the last stage, so its remaining
    // shift field is always zero and has no consumer.
    shift_t s2_shift_unused;

    rotl_stage #(.STAGE(0)) u_stage_0 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .valid_i    (in_valid_i),
        .data_i     (in_data_i),
        .shift_i    (shift_i),
        .next_adv_i (adv_1),
        .adv_o      (adv_0),
        .valid_o    (s0_valid),
        .data_o     (s0_data),
        .shift_o    (s0_shift)
    );

    rotl_stage #(.STAGE(1)) u_stage_1 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .valid_i    (s0_valid),
        .data_i     (s0_data),
        .shift_i    (s0_shift),
        .next_adv_i (adv_2),
        .adv_o      (adv_1),
        .valid_o    (s1_valid),
        .data_o     (s1_data),
        .shift_o    (s1_shift)
    );

    rotl_stage #(.STAGE(2)) u_stage_2 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .valid_i    (s1_valid),
        .data_i     (s1_data),
        .shift_i    (s1_shift),
        .next_adv_i (adv_3),
        .adv_o      (adv_2),
        .valid_o    (s2_valid),
        .data_o     (s2_data),
        .shift_o    (s2_shift_unused)
    );

    // The ready chain is purely combinational back to the input, so a full
    // pipeline that is being drained still takes a new beat in the same cycle.
    assign in_ready_o = adv_0;

    generate
        if (REG_OUT != 0) begin : g_out_reg
            logic  out_valid_reg;
            data_t out_data_reg;

            assign adv_3 = !out_valid_reg || out_ready_i;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                end else if (adv_3) begin
                    out_valid_reg <= s2_valid;
                    if (s2_valid) begin
                        out_data_reg <= s2_data;
                    end
                end
            end

            assign out_valid_o = out_valid_reg;
            assign out_data_o  = out_data_reg;
        end else begin : g_out_direct
            assign adv_3       = out_ready_i;
            assign out_valid_o = s2_valid;
            assign out_data_o  = s2_data;
        end
    endgenerate

endmodule : rotl_64b
